// File: rtl/input_handshake_unit.sv
// Front-panel input stage: debounces the Enter/Swap push-buttons, turns an
// accepted Swap press into a one-cycle pulse, and runs the IN-instruction
// handshake (Halt while waiting, capture switches on Enter, one-cycle InAck).

// Per-button debouncer: 2-flop synchronizer, stability counter, press pulse.
module input_handshake_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);
    // Counter only needs to reach DEBOUNCE_CYCLES-1 before the state flips.
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_state;
    logic          r_press;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    // Mismatch between synchronized key and accepted state; done on the last stable edge.
    assign w_diff = (r_sync2 != r_state);
    assign w_done = w_diff && (r_cnt == CNT_LAST);

    // Two-stage synchronizer for the asynchronous raw key (idles released = 1).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: counts consecutive mismatching edges, accepts the new level at the end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_state <= 1'b1;
        end else if (w_done) begin
            r_cnt   <= '0;
            r_state <= r_sync2;
        end else if (w_diff) begin
            r_cnt   <= r_cnt + CW'(1);
        end else begin
            r_cnt   <= '0;
        end
    end

    // Press pulse: one cycle after the accepted state falls from released to pressed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_press <= 1'b0;
        end else begin
            r_press <= w_done && r_state;
        end
    end

    assign o_press = r_press;
endmodule

// Top level: two debouncers plus the IN handshake state machine.
module input_handshake_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SW_WIDTH        = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_key_enter,
    input  logic                i_key_swap,
    input  logic [SW_WIDTH-1:0] i_switches,
    input  logic                i_in_request,
    output logic [31:0]         o_data_io,
    output logic                o_in_ack,
    output logic                o_halt,
    output logic                o_swap
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_capture;
    logic        w_enter_evt;
    logic        w_swap_evt;
    logic        r_halt;
    logic        r_ack;
    logic [31:0] r_data;
    logic [31:0] w_sw_ext;

    input_handshake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_key_enter),
        .o_press (w_enter_evt)
    );

    input_handshake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_swap (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_key_swap),
        .o_press (w_swap_evt)
    );

    // Switches are unsigned, so the cast zero-extends onto the 32-bit bus.
    assign w_sw_ext = 32'(i_switches);

    // Next-state logic; Enter only matters while the processor is waiting.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_in_request) begin
                    w_next = ST_WAIT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_enter_evt) begin
                    w_next    = ST_ACK;
                    w_capture = 1'b1;
                end else begin
                    w_next    = ST_WAIT;
                end
            end
            ST_ACK: begin
                w_next = ST_DROP;
            end
            ST_DROP: begin
                if (!i_in_request) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_DROP;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered decodes of the upcoming state so Halt/InAck line up with the state itself.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_halt <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_halt <= (w_next == ST_WAIT);
            r_ack  <= (w_next == ST_ACK);
        end
    end

    // DataIO capture register: loads only on the accepting Enter, otherwise holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= 32'h0000_0000;
        end else if (w_capture) begin
            r_data <= w_sw_ext;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_data_io = r_data;
    assign o_in_ack  = r_ack;
    assign o_halt    = r_halt;
    assign o_swap    = w_swap_evt;
endmodule

// File: tb/tb_input_handshake_unit.sv
// Bench for input_handshake_unit with a short debounce window: directed
// scenarios plus randomized key/request/switch activity against a reference model.
module tb_input_handshake_unit;
    localparam int DB = 4;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_enter = 1'b1;
    logic          key_swap = 1'b1;
    logic          in_req = 1'b0;
    logic [SW-1:0] sw = '0;
    logic [31:0]   data_io;
    logic          in_ack;
    logic          halt;
    logic          swap;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    input_handshake_unit #(.DEBOUNCE_CYCLES(DB), .SW_WIDTH(SW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key_enter  (key_enter),
        .i_key_swap   (key_swap),
        .i_switches   (sw),
        .i_in_request (in_req),
        .o_data_io    (data_io),
        .o_in_ack     (in_ack),
        .o_halt       (halt),
        .o_swap       (swap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model. A button's accepted level flips when the level seen two
    // edges late has disagreed with it on each of the last DB edges.
    logic          m_raw  [2];
    logic [1:0]    m_pipe [2];
    logic [DB-1:0] m_win  [2];
    logic [DB-1:0] m_nwin [2];
    logic          m_deb  [2];
    logic          m_flip [2];
    logic          m_evt  [2];
    int            m_phase;        // 0 idle, 1 waiting, 2 acking, 3 waiting for request drop
    logic [31:0]   m_data;

    always_comb begin
        m_raw[0] = key_enter;
        m_raw[1] = key_swap;
        for (int b = 0; b < 2; b++) begin
            m_nwin[b] = {m_win[b][DB-2:0], m_pipe[b][1]};
            m_flip[b] = (m_nwin[b] == {DB{~m_deb[b]}});
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                m_pipe[b] <= 2'b11;
                m_win[b]  <= '1;
                m_deb[b]  <= 1'b1;
                m_evt[b]  <= 1'b0;
            end
            m_phase <= 0;
            m_data  <= 32'h0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                m_pipe[b] <= {m_pipe[b][0], m_raw[b]};
                m_win[b]  <= m_nwin[b];
                if (m_flip[b]) m_deb[b] <= ~m_deb[b];
                m_evt[b]  <= m_flip[b] && m_deb[b];
            end
            case (m_phase)
                0: if (in_req) m_phase <= 1;
                1: if (m_evt[0]) begin
                       m_data  <= 32'(sw);
                       m_phase <= 2;
                   end
                2: m_phase <= 3;
                3: if (!in_req) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    // Every cycle, away from the active edge, outputs must match the model.
    always @(negedge clk) begin
        check("cyc_halt", 32'(halt),   32'(m_phase == 1));
        check("cyc_ack",  32'(in_ack), 32'(m_phase == 2));
        check("cyc_swap", 32'(swap),   32'(m_evt[1]));
        check("cyc_data", data_io,     m_data);
    end

    task automatic count_swap(input int n, output int hi);
        hi = 0;
        for (int e = 0; e < n; e++) begin
            @(posedge clk); #1;
            if (swap) hi++;
        end
    endtask

    task automatic count_ack(input int n, output int hi);
        hi = 0;
        for (int e = 0; e < n; e++) begin
            @(posedge clk); #1;
            if (in_ack) hi++;
        end
    endtask

    task automatic wait_ack(input string tag);
        int got;
        got = 0;
        for (int e = 0; e < 30 && got == 0; e++) begin
            @(posedge clk); #1;
            if (in_ack) got = 1;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_halt"}, 32'(halt),   32'd0);
        check({tag, "_ack"},  32'(in_ack), 32'd0);
        check({tag, "_swap"}, 32'(swap),   32'd0);
        check({tag, "_data"}, data_io,     32'h0);
    endtask

    initial begin
        int c1, c2, c3, first, kc0, kc1, rc;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst_init");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Bouncing Swap, then a stable press: one pulse, 6 edges after the final 0.
        for (int i = 0; i < 10; i++) begin
            key_swap = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
        end
        key_swap = 1'b0;
        c1 = 0;
        first = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (swap) begin
                c1++;
                if (first < 0) first = e;
            end
        end
        check("bounce_pulses", 32'(c1), 32'd1);
        check("bounce_latency", 32'(first), 32'd6);
        key_swap = 1'b1;
        count_swap(10, c1);

        // Long hold, release, press again: exactly two one-cycle pulses.
        key_swap = 1'b0;
        count_swap(100, c1);
        key_swap = 1'b1;
        count_swap(10, c2);
        key_swap = 1'b0;
        count_swap(20, c3);
        check("hold_first", 32'(c1), 32'd1);
        check("hold_release", 32'(c2), 32'd0);
        check("hold_total", 32'(c1 + c2 + c3), 32'd2);
        key_swap = 1'b1;
        count_swap(10, c1);

        // IN handshake with capture of 16'h00A5.
        @(negedge clk);
        sw = 16'h00A5;
        in_req = 1'b1;
        @(posedge clk); #1;
        check("in_halt_rise", 32'(halt), 32'd1);
        key_enter = 1'b0;
        wait_ack("in_ack_seen");
        check("in_data", data_io, 32'h0000_00A5);
        check("in_halt_at_ack", 32'(halt), 32'd0);
        @(posedge clk); #1;
        check("in_ack_single", 32'(in_ack), 32'd0);
        key_enter = 1'b1;
        count_ack(10, c1);
        sw = 16'h1234;
        key_enter = 1'b0;
        count_ack(20, c1);
        check("second_press_ack", 32'(c1), 32'd0);
        check("second_press_data", data_io, 32'h0000_00A5);
        key_enter = 1'b1;
        in_req = 1'b0;
        count_ack(10, c1);
        check("drop_halt", 32'(halt), 32'd0);

        // Enter while idle is ignored.
        sw = 16'hFFFF;
        key_enter = 1'b0;
        count_ack(20, c1);
        check("idle_enter_ack", 32'(c1), 32'd0);
        check("idle_enter_data", data_io, 32'h0000_00A5);
        key_enter = 1'b1;
        count_ack(10, c1);

        // Reset while waiting, request still high: WAIT again one edge after release.
        in_req = 1'b1;
        @(posedge clk); #1;
        check("wait_before_rst", 32'(halt), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_wait");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("halt_after_release", 32'(halt), 32'd1);
        key_enter = 1'b0;
        wait_ack("rst_ack_seen");
        check("rst_capture", data_io, 32'h0000_FFFF);
        key_enter = 1'b1;
        in_req = 1'b0;
        count_ack(10, c1);

        // Randomized activity: keys hold for random spans, occasional resets.
        kc0 = 0; kc1 = 0; rc = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (kc0 == 0) begin
                key_enter = 1'($urandom_range(0, 1));
                kc0 = $urandom_range(1, 12);
            end
            if (kc1 == 0) begin
                key_swap = 1'($urandom_range(0, 1));
                kc1 = $urandom_range(1, 12);
            end
            if (rc == 0) begin
                in_req = 1'($urandom_range(0, 1));
                rc = $urandom_range(1, 40);
            end
            kc0--; kc1--; rc--;
            sw = 16'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
